// File: rtl/ddr3_bist_pkg.sv
// Shared definitions for the DDR3 BIST: FIFO command encodings, default widths,
// FSM states and small helpers for the pattern generator and checker.
package ddr3_bist_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 27;
    localparam int unsigned DEF_DATA_WIDTH = 128;
    localparam int unsigned DEF_MASK_WIDTH = 16;
    localparam int unsigned DEF_BRST_WIDTH = 6;

    localparam logic [1:0] FIFO_IDE_TYPE = 2'd0;
    localparam logic [1:0] FIFO_CMD_TYPE = 2'd1;
    localparam logic [1:0] FIFO_WT_TYPE  = 2'd2;
    localparam logic [1:0] FIFO_RD_TYPE  = 2'd3;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shift form)
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_CAL,
        ST_WR_IDE,
        ST_WR_CMD,
        ST_WR_DATA,
        ST_RD_IDE,
        ST_RD_CMD,
        ST_RD_DATA,
        ST_FIN
    } bist_state_e;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ddr3_bist_pattern.sv
// Beat pattern source. Default: SEED + global beat index, replicated per 32-bit lane.
// With DDR3_BIST_LFSR_EN defined: a Galois LFSR reloaded by load and advanced by step.
module ddr3_bist_pattern
    import ddr3_bist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [31:0] SEED       = 32'h1357_2468
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [31:0]           idx,
    output logic [DATA_WIDTH-1:0] word
);

    localparam int unsigned REPS = DATA_WIDTH / 32;

`ifdef DDR3_BIST_LFSR_EN
    logic [31:0] lfsr_q;
    logic        unused_idx;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            lfsr_q <= SEED;
        end else if (step) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign word       = {REPS{lfsr_q}};
    assign unused_idx = ^idx;
`else
    logic [31:0] inc_word;
    logic        unused_ctl;

    assign inc_word   = SEED + idx;
    assign word       = {REPS{inc_word}};
    assign unused_ctl = ^{clk, rst, load, step};
`endif

endmodule

// File: rtl/ddr3_bist.sv
// DDR3 traffic generator/checker driving the bridge FIFO interface: write a pattern,
// read it back, count mismatches. Pattern type selected by DDR3_BIST_LFSR_EN.
module ddr3_bist
    import ddr3_bist_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MASK_WIDTH = DEF_MASK_WIDTH,
    parameter int unsigned BRST_WIDTH = DEF_BRST_WIDTH,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned NUM_BURST  = 4,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned ADDR_STEP  = 64,
    parameter logic [31:0] SEED       = 32'h1357_2468
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  calib_done,
    output logic                  io_fifo_cmd_valid,
    input  logic                  io_fifo_cmd_ready,
    output logic [1:0]            io_fifo_cmd_type,
    output logic [ADDR_WIDTH-1:0] io_fifo_cmd_addr,
    output logic [BRST_WIDTH-1:0] io_fifo_cmd_burst_cnt,
    output logic [DATA_WIDTH-1:0] io_fifo_cmd_wt_data,
    output logic [MASK_WIDTH-1:0] io_fifo_cmd_wt_mask,
    output logic                  io_fifo_rsp_valid,
    input  logic                  io_fifo_rsp_ready,
    input  logic [DATA_WIDTH-1:0] io_fifo_rsp_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_cnt,
    output logic [15:0]           first_err_idx
);

    localparam int unsigned BEAT_W  = BRST_WIDTH + 1;
    localparam int unsigned BURST_W = 16;

    bist_state_e           state_q;
    logic [BEAT_W-1:0]     beat_q;
    logic [BURST_W-1:0]    burst_q;
    logic [31:0]           gidx_q;
    logic [DATA_WIDTH-1:0] pat_word;
    logic [ADDR_WIDTH-1:0] burst_addr;
    logic cmd_fire, rsp_fire, last_beat, last_burst;
    logic wr_load, pat_step, pat_load, mismatch;

    assign cmd_fire   = io_fifo_cmd_valid && io_fifo_cmd_ready;
    assign rsp_fire   = io_fifo_rsp_valid && io_fifo_rsp_ready;
    assign last_beat  = (beat_q == BEAT_W'(BURST_LEN - 1));
    assign last_burst = (burst_q == BURST_W'(NUM_BURST - 1));
    assign burst_addr = ADDR_WIDTH'(BASE_ADDR + 32'(burst_q) * ADDR_STEP);
    assign mismatch   = (io_fifo_rsp_data != pat_word);

    // Pattern advances whenever a write beat is loaded into the output register
    // or a read beat is consumed; it rewinds when idle and at the write/read turn.
    assign wr_load  = cmd_fire && ((state_q == ST_WR_IDE) ||
                      (((state_q == ST_WR_CMD) || (state_q == ST_WR_DATA)) && !last_beat));
    assign pat_step = wr_load || ((state_q == ST_RD_DATA) && rsp_fire);
    assign pat_load = (state_q == ST_IDLE) ||
                      (cmd_fire && ((state_q == ST_WR_CMD) || (state_q == ST_WR_DATA)) &&
                       last_beat && last_burst);

    assign io_fifo_cmd_wt_mask = '0;

    ddr3_bist_pattern #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEED       (SEED)
    ) u_pattern (
        .clk  (clk),
        .rst  (rst),
        .load (pat_load),
        .step (pat_step),
        .idx  (gidx_q),
        .word (pat_word)
    );

    always_ff @(posedge clk) begin
        if (rst || pat_load) begin
            gidx_q <= '0;
        end else if (pat_step) begin
            gidx_q <= gidx_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q               <= ST_IDLE;
            beat_q                <= '0;
            burst_q               <= '0;
            io_fifo_cmd_valid     <= 1'b0;
            io_fifo_cmd_type      <= FIFO_IDE_TYPE;
            io_fifo_cmd_addr      <= '0;
            io_fifo_cmd_burst_cnt <= '0;
            io_fifo_cmd_wt_data   <= '0;
            io_fifo_rsp_valid     <= 1'b0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            pass                  <= 1'b0;
            err_cnt               <= '0;
            first_err_idx         <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    busy          <= 1'b1;
                    done          <= 1'b0;
                    pass          <= 1'b0;
                    err_cnt       <= '0;
                    first_err_idx <= '0;
                    burst_q       <= '0;
                    state_q       <= ST_WAIT_CAL;
                end
                ST_WAIT_CAL: if (calib_done) begin
                    io_fifo_cmd_valid <= 1'b1;
                    io_fifo_cmd_type  <= FIFO_IDE_TYPE;
                    state_q           <= ST_WR_IDE;
                end
                ST_WR_IDE: if (cmd_fire) begin
                    io_fifo_cmd_type      <= FIFO_CMD_TYPE;
                    io_fifo_cmd_addr      <= burst_addr;
                    io_fifo_cmd_burst_cnt <= BRST_WIDTH'(BURST_LEN - 1);
                    io_fifo_cmd_wt_data   <= pat_word;
                    beat_q                <= '0;
                    state_q               <= ST_WR_CMD;
                end
                // The CMD beat carries data beat 0; WT beats carry the rest
                ST_WR_CMD, ST_WR_DATA: if (cmd_fire) begin
                    if (last_beat) begin
                        io_fifo_cmd_type <= FIFO_IDE_TYPE;
                        if (last_burst) begin
                            burst_q <= '0;
                            state_q <= ST_RD_IDE;
                        end else begin
                            burst_q <= burst_q + BURST_W'(1);
                            state_q <= ST_WR_IDE;
                        end
                    end else begin
                        io_fifo_cmd_type    <= FIFO_WT_TYPE;
                        io_fifo_cmd_wt_data <= pat_word;
                        beat_q              <= beat_q + BEAT_W'(1);
                        state_q             <= ST_WR_DATA;
                    end
                end
                ST_RD_IDE: if (cmd_fire) begin
                    io_fifo_cmd_type      <= FIFO_RD_TYPE;
                    io_fifo_cmd_addr      <= burst_addr;
                    io_fifo_cmd_burst_cnt <= BRST_WIDTH'(BURST_LEN - 1);
                    state_q               <= ST_RD_CMD;
                end
                ST_RD_CMD: if (cmd_fire) begin
                    io_fifo_cmd_valid <= 1'b0;
                    io_fifo_rsp_valid <= 1'b1;
                    beat_q            <= '0;
                    state_q           <= ST_RD_DATA;
                end
                ST_RD_DATA: if (rsp_fire) begin
                    if (mismatch) begin
                        err_cnt <= sat_inc16(err_cnt);
                        if (err_cnt == 16'd0) begin
                            first_err_idx <= 16'(gidx_q);
                        end
                    end
                    if (last_beat) begin
                        io_fifo_rsp_valid <= 1'b0;
                        if (last_burst) begin
                            state_q <= ST_FIN;
                        end else begin
                            burst_q           <= burst_q + BURST_W'(1);
                            io_fifo_cmd_valid <= 1'b1;
                            io_fifo_cmd_type  <= FIFO_IDE_TYPE;
                            state_q           <= ST_RD_IDE;
                        end
                    end else begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                ST_FIN: begin
                    busy             <= 1'b0;
                    done             <= 1'b1;
                    pass             <= (err_cnt == 16'd0);
                    io_fifo_cmd_type <= FIFO_IDE_TYPE;
                    state_q          <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_bist.sv
// Bench for ddr3_bist: loopback bridge model with optional stalls and read corruption,
// checked against an expected command/beat sequence derived from the pattern rules.
module tb_ddr3_bist;

    localparam logic [31:0] SEED = 32'h1357_2468;
    localparam logic [1:0] T_IDE = 2'd0, T_CMD = 2'd1, T_WT = 2'd2, T_RD = 2'd3;

    typedef struct packed {
        logic [1:0]   t;
        logic [26:0]  a;
        logic [5:0]   c;
        logic [127:0] d;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic calib_done = 1'b1;
    logic [1:0] start = '0;
    logic [1:0] cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0] busy, done, pass;
    logic [1:0][1:0] cmd_type;
    logic [1:0][26:0] cmd_addr;
    logic [1:0][5:0] cmd_cnt;
    logic [1:0][127:0] wt_data, rsp_data;
    logic [1:0][15:0] wt_mask, err_cnt, first_err;

    ddr3_bist dut (
        .clk(clk), .rst(rst), .start(start[0]), .calib_done(calib_done),
        .io_fifo_cmd_valid(cmd_valid[0]), .io_fifo_cmd_ready(cmd_ready[0]),
        .io_fifo_cmd_type(cmd_type[0]), .io_fifo_cmd_addr(cmd_addr[0]),
        .io_fifo_cmd_burst_cnt(cmd_cnt[0]), .io_fifo_cmd_wt_data(wt_data[0]),
        .io_fifo_cmd_wt_mask(wt_mask[0]), .io_fifo_rsp_valid(rsp_valid[0]),
        .io_fifo_rsp_ready(rsp_ready[0]), .io_fifo_rsp_data(rsp_data[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_cnt(err_cnt[0]), .first_err_idx(first_err[0])
    );

    ddr3_bist #(.BURST_LEN(1), .NUM_BURST(2)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .calib_done(calib_done),
        .io_fifo_cmd_valid(cmd_valid[1]), .io_fifo_cmd_ready(cmd_ready[1]),
        .io_fifo_cmd_type(cmd_type[1]), .io_fifo_cmd_addr(cmd_addr[1]),
        .io_fifo_cmd_burst_cnt(cmd_cnt[1]), .io_fifo_cmd_wt_data(wt_data[1]),
        .io_fifo_cmd_wt_mask(wt_mask[1]), .io_fifo_rsp_valid(rsp_valid[1]),
        .io_fifo_rsp_ready(rsp_ready[1]), .io_fifo_rsp_data(rsp_data[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_cnt(err_cnt[1]), .first_err_idx(first_err[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bridge model state
    beat_t log0[$], log1[$], exp_q[$];
    logic [127:0] rdq0[$], rdq1[$];
    logic [127:0] mem [int];
    int cur_addr [2];
    int cur_beat [2];
    int rd_cnt0 = 0, rd_cnt1 = 0;
    int corrupt_idx = -1;
    int cyc = 0;
    bit ready_mode = 0, rsp_gaps = 0, chk_stable = 0, stalled_prev = 0;
    beat_t prev_pay;

    function automatic int mkey(input int i, input int addr);
        return i * (1 << 28) + addr;
    endfunction

    function automatic logic [127:0] exp_word(input int g);
        logic [31:0] w;
`ifdef DDR3_BIST_LFSR_EN
        w = SEED;
        repeat (g) w = (w >> 1) ^ (w[0] ? 32'h8020_0003 : 32'h0);
`else
        w = SEED + 32'(g);
`endif
        return {4{w}};
    endfunction

    function automatic beat_t norm(input beat_t b);
        beat_t r = b;
        case (b.t)
            T_IDE:   begin r.a = '0; r.c = '0; r.d = '0; end
            T_WT:    begin r.a = '0; r.c = '0; end
            T_RD:    r.d = '0;
            default: ;
        endcase
        return r;
    endfunction

    function automatic void record(input int i, input beat_t b);
        if (i == 0) log0.push_back(b); else log1.push_back(b);
        case (b.t)
            T_CMD: begin
                cur_addr[i] = int'(b.a);
                cur_beat[i] = 1;
                mem[mkey(i, int'(b.a))] = b.d;
            end
            T_WT: begin
                mem[mkey(i, cur_addr[i] + cur_beat[i])] = b.d;
                cur_beat[i]++;
            end
            T_RD: for (int k = 0; k <= int'(b.c); k++) begin
                logic [127:0] v;
                v = mem.exists(mkey(i, int'(b.a) + k)) ? mem[mkey(i, int'(b.a) + k)] : '0;
                if (i == 0) rdq0.push_back(v); else rdq1.push_back(v);
            end
            default: ;
        endcase
    endfunction

    // Inputs change on the falling edge; a transfer is logged when valid&&ready
    // are both set here, since they hold through the next rising edge.
    always @(negedge clk) begin
        beat_t now0, now1;
        cyc++;
        now0 = {cmd_type[0], cmd_addr[0], cmd_cnt[0], wt_data[0]};
        now1 = {cmd_type[1], cmd_addr[1], cmd_cnt[1], wt_data[1]};
        if (chk_stable && stalled_prev)
            check("stall_hold", 200'({cmd_valid[0], now0}), 200'({1'b1, prev_pay}));
        cmd_ready[0] = ready_mode ? (cyc % 3 == 0) : 1'b1;
        cmd_ready[1] = 1'b1;
        stalled_prev = cmd_valid[0] && !cmd_ready[0];
        prev_pay = now0;
        if (cmd_valid[0] && cmd_ready[0] && !rst) record(0, now0);
        if (cmd_valid[1] && cmd_ready[1] && !rst) record(1, now1);

        rsp_ready[0] = (rdq0.size() > 0) && (!rsp_gaps || $urandom_range(0, 2) != 0);
        rsp_data[0]  = rsp_ready[0] ?
                       (rdq0[0] ^ ((rd_cnt0 == corrupt_idx) ? 128'd1 : 128'd0)) : 128'd0;
        if (rsp_valid[0] && rsp_ready[0]) begin
            void'(rdq0.pop_front());
            rd_cnt0++;
        end
        rsp_ready[1] = (rdq1.size() > 0);
        rsp_data[1]  = rsp_ready[1] ? rdq1[0] : 128'd0;
        if (rsp_valid[1] && rsp_ready[1]) begin
            void'(rdq1.pop_front());
            rd_cnt1++;
        end
    end

    task automatic build_exp(input int bl, input int nb);
        exp_q.delete();
        for (int b = 0; b < nb; b++) begin
            exp_q.push_back({T_IDE, 27'd0, 6'd0, 128'd0});
            exp_q.push_back({T_CMD, 27'(b * 64), 6'(bl - 1), exp_word(b * bl)});
            for (int k = 1; k < bl; k++)
                exp_q.push_back({T_WT, 27'd0, 6'd0, exp_word(b * bl + k)});
        end
        for (int b = 0; b < nb; b++) begin
            exp_q.push_back({T_IDE, 27'd0, 6'd0, 128'd0});
            exp_q.push_back({T_RD, 27'(b * 64), 6'(bl - 1), 128'd0});
        end
    endtask

    task automatic check_log(input int i, input string tag);
        beat_t q[$];
        int n;
        if (i == 0) q = log0; else q = log1;
        check({tag, "_beat_count"}, 200'(q.size()), 200'(exp_q.size()));
        n = (q.size() < exp_q.size()) ? q.size() : exp_q.size();
        for (int j = 0; j < n; j++)
            check($sformatf("%s_beat%0d", tag, j), 200'(norm(q[j])), 200'(norm(exp_q[j])));
    endtask

    task automatic clear_model(input int i);
        if (i == 0) begin
            log0.delete(); rdq0.delete(); rd_cnt0 = 0;
        end else begin
            log1.delete(); rdq1.delete(); rd_cnt1 = 0;
        end
        mem.delete();
    endtask

    task automatic pulse_start(input int i);
        @(negedge clk); start[i] = 1'b1;
        @(negedge clk); start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input string tag);
        int n = 0;
        while (!done[i] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 200'(done[i]), 200'(1));
        check({tag, "_busy"}, 200'(busy[i]), 200'(0));
    endtask

    task automatic check_stats(input int i, input string tag, input int ec, input int fe, input bit ps);
        check({tag, "_err_cnt"}, 200'(err_cnt[i]), 200'(ec));
        check({tag, "_first_err"}, 200'(first_err[i]), 200'(fe));
        check({tag, "_pass"}, 200'(pass[i]), 200'(ps));
    endtask

    initial begin
        int n;
        bit seen, found;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_valid", 200'(cmd_valid[0]), 200'(0));
        check("rst_cmd_type", 200'(cmd_type[0]), 200'(0));
        check("rst_cmd_addr", 200'(cmd_addr[0]), 200'(0));
        check("rst_wt_data", 200'(wt_data[0]), 200'(0));
        check("rst_wt_mask", 200'(wt_mask[0]), 200'(0));
        check("rst_rsp_valid", 200'(rsp_valid[0]), 200'(0));
        check("rst_busy", 200'(busy[0]), 200'(0));
        check("rst_done", 200'(done[0]), 200'(0));
        check("rst_pass", 200'(pass[0]), 200'(0));
        check_stats(0, "rst", 0, 0, 0);
        rst = 1'b0;

        // 1: clean loopback run
        build_exp(8, 4);
        clear_model(0);
        pulse_start(0);
        wait_done(0, "t1");
        check_log(0, "t1");
        check_stats(0, "t1", 0, 0, 1);

        // 2: single corrupted read beat
        corrupt_idx = 11;
        clear_model(0);
        pulse_start(0);
        wait_done(0, "t2");
        check_stats(0, "t2", 1, 11, 0);
        corrupt_idx = -1;

        // 3: command stalls and response gaps
        ready_mode = 1; rsp_gaps = 1; chk_stable = 1;
        clear_model(0);
        pulse_start(0);
        wait_done(0, "t3");
        check_log(0, "t3");
        check_stats(0, "t3", 0, 0, 1);
        ready_mode = 0; rsp_gaps = 0; chk_stable = 0;

        // 4: calibration delayed after start
        calib_done = 1'b0;
        clear_model(0);
        pulse_start(0);
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (cmd_valid[0]) seen = 1;
        end
        check("t4_no_valid_before_cal", 200'(seen), 200'(0));
        check("t4_busy_waiting", 200'(busy[0]), 200'(1));
        calib_done = 1'b1;
        wait_done(0, "t4");
        check_log(0, "t4");
        check_stats(0, "t4", 0, 0, 1);

        // 5: reset during burst 2, write beat 3, then a fresh run
        clear_model(0);
        pulse_start(0);
        found = 0;
        n = 0;
        while (!found && n < 2000) begin
            @(negedge clk);
            if (cmd_valid[0] && cmd_type[0] == T_WT && cmd_addr[0] == 27'd128 &&
                wt_data[0] == exp_word(19))
                found = 1;
            n++;
        end
        check("t5_reached_beat", 200'(found), 200'(1));
        rst = 1'b1;
        @(negedge clk);
        check("t5_cmd_valid", 200'(cmd_valid[0]), 200'(0));
        check("t5_rsp_valid", 200'(rsp_valid[0]), 200'(0));
        check("t5_busy", 200'(busy[0]), 200'(0));
        check("t5_err_cnt", 200'(err_cnt[0]), 200'(0));
        rst = 1'b0;
        clear_model(0);
        pulse_start(0);
        wait_done(0, "t5_rerun");
        check_log(0, "t5_rerun");
        check_stats(0, "t5_rerun", 0, 0, 1);

        // 6: single-beat bursts, two bursts
        build_exp(1, 2);
        clear_model(1);
        pulse_start(1);
        wait_done(1, "t6");
        check_log(1, "t6");
        check_stats(1, "t6", 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
